// File: rtl/cpu_defs_pkg.sv
// Shared CPU definitions: reset/NOP words, IF state encoding, stall-vector bit positions.
package cpu_defs_pkg;

    localparam logic [31:0] ZERO_WORD = 32'h0000_0000;
    localparam logic [31:0] NOP_INST  = 32'h0000_0000;
    localparam logic [31:0] RESET_PC  = 32'h0000_0000;

    // Instruction ROM word-index width; ROM index = rom_addr[ROM_AW+1:2]
    localparam int unsigned ROM_AW = 9;

    // Bit positions inside the pipeline stall vector
    localparam int unsigned STALL_IF_BIT = 0;
    localparam int unsigned STALL_ID_BIT = 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_HOLD  = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: captures {pc, inst}, holds on ID stall, bubbles on flush/IF stall.
module if_id_reg
    import cpu_defs_pkg::*;
#(
    parameter logic [31:0] NOP_INST = cpu_defs_pkg::NOP_INST
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        stall_if,
    input  logic        stall_id,
    input  logic        fetch_en,
    input  logic [31:0] pc,
    input  logic [31:0] inst,
    output logic [31:0] id_pc,
    output logic [31:0] id_inst,
    output logic        id_valid
);

    // Flush beats hold; an IF stall with ID free (or no fetch yet) inserts a bubble
    always_ff @(posedge clk) begin
        if (rst) begin
            id_pc    <= ZERO_WORD;
            id_inst  <= NOP_INST;
            id_valid <= 1'b0;
        end else if (flush) begin
            id_pc    <= ZERO_WORD;
            id_inst  <= NOP_INST;
            id_valid <= 1'b0;
        end else if (stall_id) begin
            id_pc    <= id_pc;
            id_inst  <= id_inst;
            id_valid <= id_valid;
        end else if (stall_if || !fetch_en) begin
            id_pc    <= ZERO_WORD;
            id_inst  <= NOP_INST;
            id_valid <= 1'b0;
        end else begin
            id_pc    <= pc;
            id_inst  <= inst;
            id_valid <= 1'b1;
        end
    end

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: PC, fetch FSM, branch-pending latch and the IF/ID register.
module if_fetch_stage
    import cpu_defs_pkg::*;
#(
    parameter logic [31:0] RESET_PC = cpu_defs_pkg::RESET_PC,
    parameter logic [31:0] NOP_INST = cpu_defs_pkg::NOP_INST
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_if,
    input  logic        stall_id,
    input  logic        flush,
    input  logic [31:0] new_pc,
    input  logic        branch_flag,
    input  logic [31:0] branch_target,
    output logic        rom_ce,
    output logic [31:0] rom_addr,
    input  logic [31:0] rom_inst,
    output logic [31:0] id_pc,
    output logic [31:0] id_inst,
    output logic        id_valid
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic         br_pend_q, br_pend_d;
    logic [31:0]  br_tgt_q, br_tgt_d;
    logic         fetch_en;

    assign fetch_en = (state_q != S_IDLE);
    assign rom_ce   = fetch_en;
    assign rom_addr = pc_q;

    // State, PC and branch-pending registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            pc_q      <= RESET_PC;
            br_pend_q <= 1'b0;
            br_tgt_q  <= ZERO_WORD;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            br_pend_q <= br_pend_d;
            br_tgt_q  <= br_tgt_d;
        end
    end

    // Fetch FSM next state; IDLE lasts exactly one cycle after reset
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  state_d = S_FETCH;
            S_FETCH: if (stall_if && !flush) state_d = S_HOLD;
            S_HOLD:  if (!stall_if || flush) state_d = S_FETCH;
            default: state_d = S_IDLE;
        endcase
    end

    // PC next value; a branch seen during an IF stall is parked until the stall releases
    always_comb begin
        pc_d      = pc_q;
        br_pend_d = br_pend_q;
        br_tgt_d  = br_tgt_q;
        if (fetch_en) begin
            if (flush) begin
                pc_d      = new_pc;
                br_pend_d = 1'b0;
            end else if (stall_if) begin
                if (branch_flag) begin
                    br_pend_d = 1'b1;
                    br_tgt_d  = branch_target;
                end
            end else if (br_pend_q) begin
                pc_d      = br_tgt_q;
                br_pend_d = 1'b0;
            end else if (branch_flag) begin
                pc_d = branch_target;
            end else begin
                pc_d = pc_q + 32'd4;
            end
        end
    end

    if_id_reg #(
        .NOP_INST (NOP_INST)
    ) u_if_id_reg (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .stall_if (stall_if),
        .stall_id (stall_id),
        .fetch_en (fetch_en),
        .pc       (pc_q),
        .inst     (rom_inst),
        .id_pc    (id_pc),
        .id_inst  (id_inst),
        .id_valid (id_valid)
    );

endmodule

// File: tb/tb_if_fetch_stage.sv
// Bench for if_fetch_stage: directed scenarios with literal expectations plus random stimulus
// checked every cycle against a behavioural model.
module tb_if_fetch_stage;

    localparam int unsigned AW    = cpu_defs_pkg::ROM_AW;
    localparam int unsigned WORDS = 1 << AW;
    localparam logic [31:0] NOP   = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall_if, stall_id, flush, branch_flag;
    logic [31:0] new_pc, branch_target;
    logic        rom_ce;
    logic [31:0] rom_addr, rom_inst;
    logic [31:0] id_pc, id_inst;
    logic        id_valid;

    logic [31:0] rom [0:WORDS-1];
    assign rom_inst = rom[rom_addr[AW+1:2]];

    always #5 clk = ~clk;

    if_fetch_stage dut (
        .clk           (clk),
        .rst           (rst),
        .stall_if      (stall_if),
        .stall_id      (stall_id),
        .flush         (flush),
        .new_pc        (new_pc),
        .branch_flag   (branch_flag),
        .branch_target (branch_target),
        .rom_ce        (rom_ce),
        .rom_addr      (rom_addr),
        .rom_inst      (rom_inst),
        .id_pc         (id_pc),
        .id_inst       (id_inst),
        .id_valid      (id_valid)
    );

    int n_chk  = 0;
    int n_pass = 0;
    bit cmp_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Behavioural model: fetching starts one cycle after reset, then the PC follows
    // flush > stall (park branch) > parked branch > branch > +4.
    bit          m_active;
    logic [31:0] m_pc, m_tgt, m_id_pc, m_id_inst;
    bit          m_pend, m_id_valid;

    always @(posedge clk) begin
        if (rst) begin
            m_active   <= 1'b0;
            m_pc       <= 32'h0;
            m_pend     <= 1'b0;
            m_tgt      <= 32'h0;
            m_id_pc    <= 32'h0;
            m_id_inst  <= NOP;
            m_id_valid <= 1'b0;
        end else begin
            if (flush || (!stall_id && (stall_if || !m_active))) begin
                m_id_pc    <= 32'h0;
                m_id_inst  <= NOP;
                m_id_valid <= 1'b0;
            end else if (!stall_id) begin
                m_id_pc    <= m_pc;
                m_id_inst  <= rom[m_pc[AW+1:2]];
                m_id_valid <= 1'b1;
            end
            if (m_active) begin
                if (flush) begin
                    m_pc   <= new_pc;
                    m_pend <= 1'b0;
                end else if (stall_if) begin
                    if (branch_flag) begin
                        m_pend <= 1'b1;
                        m_tgt  <= branch_target;
                    end
                end else if (m_pend) begin
                    m_pc   <= m_tgt;
                    m_pend <= 1'b0;
                end else if (branch_flag) begin
                    m_pc <= branch_target;
                end else begin
                    m_pc <= m_pc + 32'd4;
                end
            end
            m_active <= 1'b1;
        end
    end

    // Per-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("rom_ce", 32'(rom_ce), 32'(m_active));
            chk("rom_addr", rom_addr, m_pc);
            chk("id_valid", 32'(id_valid), 32'(m_id_valid));
            chk("id_pc", id_pc, m_id_pc);
            chk("id_inst", id_inst, m_id_inst);
        end
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        stall_if      = 1'b0;
        stall_id      = 1'b0;
        flush         = 1'b0;
        branch_flag   = 1'b0;
        new_pc        = 32'h0;
        branch_target = 32'h0;
    endtask

    initial begin
        for (int i = 0; i < int'(WORDS); i++) rom[i] = $urandom;
        rst = 1'b1;
        idle_inputs();
        repeat (2) @(negedge clk);
        cmp_en = 1'b1;
        rst    = 1'b0;

        // Reset release
        chk("t1_ce_cycle0", 32'(rom_ce), 32'd0);
        chk("t1_valid_cycle0", 32'(id_valid), 32'd0);
        tick();
        chk("t1_ce_cycle1", 32'(rom_ce), 32'd1);
        chk("t1_addr_cycle1", rom_addr, 32'h0);
        chk("t1_valid_cycle1", 32'(id_valid), 32'd0);
        tick();
        chk("t1_addr_cycle2", rom_addr, 32'h4);
        chk("t1_valid_cycle2", 32'(id_valid), 32'd1);
        chk("t1_inst_cycle2", id_inst, rom[0]);
        tick();
        chk("t1_addr_cycle3", rom_addr, 32'h8);
        chk("t1_idpc_cycle3", id_pc, 32'h4);
        tick();
        tick();
        chk("t1_addr_0x10", rom_addr, 32'h10);
        chk("model_pc_0x10", m_pc, 32'h10);

        // Full stall freezes PC and IF/ID, release resumes, IF-only stall bubbles
        stall_if = 1'b1;
        stall_id = 1'b1;
        repeat (3) tick();
        chk("t2_addr_frozen", rom_addr, 32'h10);
        chk("t2_idpc_frozen", id_pc, 32'hC);
        chk("t2_valid_frozen", 32'(id_valid), 32'd1);
        idle_inputs();
        tick();
        chk("t2_addr_release", rom_addr, 32'h14);
        chk("t2_idpc_release", id_pc, 32'h10);
        stall_if = 1'b1;
        tick();
        chk("t2_bubble_valid", 32'(id_valid), 32'd0);
        chk("t2_bubble_inst", id_inst, NOP);
        chk("t2_bubble_addr", rom_addr, 32'h14);
        idle_inputs();
        tick();

        // Branch with delay slot
        flush  = 1'b1;
        new_pc = 32'h8;
        tick();
        idle_inputs();
        branch_flag   = 1'b1;
        branch_target = 32'h40;
        tick();
        chk("t3_addr_target", rom_addr, 32'h40);
        chk("t3_delay_slot_pc", id_pc, 32'h8);
        chk("t3_delay_slot_inst", id_inst, rom[2]);
        idle_inputs();
        tick();
        chk("t3_addr_next", rom_addr, 32'h44);

        // Branch parked across a stall
        stall_if      = 1'b1;
        stall_id      = 1'b1;
        branch_flag   = 1'b1;
        branch_target = 32'h80;
        tick();
        branch_flag = 1'b0;
        repeat (2) tick();
        chk("t4_addr_held", rom_addr, 32'h44);
        idle_inputs();
        tick();
        chk("t4_addr_pending", rom_addr, 32'h80);
        chk("model_pc_pending", m_pc, 32'h80);

        // Flush overrides stall and branch, and drops a parked branch
        stall_if      = 1'b1;
        branch_flag   = 1'b1;
        branch_target = 32'h100;
        tick();
        flush         = 1'b1;
        new_pc        = 32'h20;
        branch_target = 32'h200;
        tick();
        chk("t5_addr_flush", rom_addr, 32'h20);
        chk("t5_valid_flush", 32'(id_valid), 32'd0);
        idle_inputs();
        tick();
        chk("t5_pend_cleared", rom_addr, 32'h24);

        // PC wrap, then reset with a branch parked
        flush  = 1'b1;
        new_pc = 32'hFFFF_FFFC;
        tick();
        idle_inputs();
        tick();
        chk("t6_wrap_addr", rom_addr, 32'h0);
        chk("t6_wrap_idpc", id_pc, 32'hFFFF_FFFC);
        chk("t6_wrap_inst", id_inst, rom[WORDS-1]);
        stall_if      = 1'b1;
        branch_flag   = 1'b1;
        branch_target = 32'h300;
        tick();
        idle_inputs();
        rst = 1'b1;
        tick();
        chk("t6_rst_ce", 32'(rom_ce), 32'd0);
        chk("t6_rst_valid", 32'(id_valid), 32'd0);
        rst = 1'b0;
        tick();
        chk("t6_rst_addr", rom_addr, 32'h0);
        tick();
        chk("t6_pend_lost", rom_addr, 32'h4);

        // Random traffic
        for (int i = 0; i < 2000; i++) begin
            rst           = ($urandom_range(63) == 0);
            flush         = ($urandom_range(15) == 0);
            stall_if      = ($urandom_range(3) == 0);
            stall_id      = ($urandom_range(3) == 0);
            branch_flag   = ($urandom_range(5) == 0);
            new_pc        = $urandom & 32'hFFFF_FFFC;
            branch_target = $urandom & 32'hFFFF_FFFC;
            tick();
        end
        rst = 1'b0;
        idle_inputs();
        tick();

        cmp_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
